// File: rtl/layer_sequencer.sv
// layer_sequencer: steps NUM_STAGES layer engines in index order.
// Optional per-stage watchdog is compiled in with SEQ_WATCHDOG_EN.
module layer_sequencer #(
  parameter int NUM_STAGES     = 5,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_skip,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  finish,
  output logic                  error,
  output logic [CNT_W-1:0]      cycle_cnt
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RUN  = 4'b0010,
    DONE = 4'b0100,
    ERR  = 4'b1000
  } state_t;

  state_t state, state_d;
  logic [NUM_STAGES-1:0] mask, mask_d;
  logic [NUM_STAGES-1:0] en_d, sp_d;
  logic [IDX_W-1:0]      cur_d;
  logic [CNT_W-1:0]      cnt_d;
  logic [IDX_W:0]        first, next;

  // {found, index} of lowest unskipped stage at or above lo
  function automatic logic [IDX_W:0] scan(
    input logic [NUM_STAGES-1:0] m,
    input int                    lo
  );
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (i >= lo && !m[i])
        r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  assign first = scan(stage_skip, 0);
  assign next  = scan(mask, int'(cur_stage) + 1);

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd, wd_d;
  logic            expired;

  assign expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign error   = (state == ERR);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else        wd <= wd_d;
`else
  assign error = 1'b0;
`endif

  assign busy   = (state == RUN);
  assign finish = (state == DONE);

  always_comb begin
    state_d = state;
    mask_d  = mask;
    cur_d   = cur_stage;
    cnt_d   = cycle_cnt;
    en_d    = '0;
    sp_d    = '0;
`ifdef SEQ_WATCHDOG_EN
    wd_d    = wd;
`endif
    if (abort) begin
      state_d = IDLE;
      mask_d  = '0;
      cur_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (1'b1)
        state[1]: begin
          if (!(&cycle_cnt))
            cnt_d = cycle_cnt + CNT_W'(1);
          if (stage_done[cur_stage]) begin
            if (next[IDX_W]) begin
              cur_d = next[IDX_W-1:0];
              en_d  = NUM_STAGES'(1) << next[IDX_W-1:0];
              sp_d  = en_d;
`ifdef SEQ_WATCHDOG_EN
              wd_d  = '0;
`endif
            end else begin
              state_d = DONE;
            end
`ifdef SEQ_WATCHDOG_EN
          end else if (expired) begin
            state_d = ERR;
          end else begin
            en_d = stage_en;
            wd_d = wd + WD_W'(1);
`else
          end else begin
            en_d = stage_en;
`endif
          end
        end
        default: begin
          if (start) begin
            mask_d = stage_skip;
            cnt_d  = '0;
            if (first[IDX_W]) begin
              state_d = RUN;
              cur_d   = first[IDX_W-1:0];
              en_d    = NUM_STAGES'(1) << first[IDX_W-1:0];
              sp_d    = en_d;
`ifdef SEQ_WATCHDOG_EN
              wd_d    = '0;
`endif
            end else begin
              state_d = DONE;
              cur_d   = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask        <= '0;
      cur_stage   <= '0;
      stage_en    <= '0;
      stage_start <= '0;
      cycle_cnt   <= '0;
    end else begin
      state       <= state_d;
      mask        <= mask_d;
      cur_stage   <= cur_d;
      stage_en    <= en_d;
      stage_start <= sp_d;
      cycle_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: vector table, directed runs and random
// stimulus checked against a queue-based run model.
module tb_layer_sequencer;

  localparam int N = 5;
`ifdef SEQ_WATCHDOG_EN
  localparam int TO = 8;
`else
  localparam int TO = 65535;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] stage_skip = '0;
  logic [N-1:0] stage_done = '0;
  logic [N-1:0] stage_en, stage_start;
  logic [2:0]   cur_stage;
  logic         busy, finish, error;
  logic [23:0]  cycle_cnt;

  int tests = 0;
  int fails = 0;

  layer_sequencer #(
    .NUM_STAGES(N),
    .CNT_W(24),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .stage_skip(stage_skip),
    .stage_done(stage_done),
    .stage_en(stage_en),
    .stage_start(stage_start),
    .cur_stage(cur_stage),
    .busy(busy),
    .finish(finish),
    .error(error),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // model: mode 0 idle, 1 run, 2 done, 3 err; q = stages still to run
  int     m_mode = 0;
  int     q[$];
  int     m_last = 0;
  int     m_age  = 0;
  bit     m_first = 0;
  longint m_cnt = 0;

  task automatic model_reset();
    m_mode = 0; q.delete(); m_last = 0;
    m_age = 0; m_first = 0; m_cnt = 0;
  endtask

  task automatic model_step(logic st, logic ab,
                            logic [N-1:0] sk, logic [N-1:0] dn);
    if (ab) begin
      model_reset();
    end else if (m_mode == 1) begin
      m_cnt = (m_cnt < 64'hFFFFFF) ? m_cnt + 1 : m_cnt;
      m_first = 0;
      if (dn[q[0]]) begin
        void'(q.pop_front());
        if (q.size() > 0) begin
          m_last = q[0]; m_first = 1; m_age = 0;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_age++;
`ifdef SEQ_WATCHDOG_EN
        if (m_age >= TO) m_mode = 3;
`endif
      end
    end else if (st) begin
      m_cnt = 0;
      q.delete();
      for (int i = 0; i < N; i++)
        if (!sk[i]) q.push_back(i);
      if (q.size() > 0) begin
        m_mode = 1; m_last = q[0]; m_first = 1; m_age = 0;
      end else begin
        m_mode = 2; m_last = 0;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_en;
    e_en = (m_mode == 1) ? (N'(1) << q[0]) : '0;
    chk("m.en", 32'(stage_en), 32'(e_en));
    chk("m.sp", 32'(stage_start), 32'(m_first && m_mode == 1 ? e_en : '0));
    chk("m.cur", 32'(cur_stage), 32'(m_last));
    chk("m.busy", 32'(busy), 32'(m_mode == 1));
    chk("m.fin", 32'(finish), 32'(m_mode == 2));
    chk("m.err", 32'(error), 32'(m_mode == 3));
    chk("m.cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic cyc(logic st, logic ab, logic [N-1:0] sk, logic [N-1:0] dn);
    start = st; abort = ab; stage_skip = sk; stage_done = dn;
    @(posedge clk);
    model_step(st, ab, sk, dn);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    start = 0; abort = 0; stage_skip = '0; stage_done = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.en", 32'(stage_en), 0);
    chk("rst.cnt", 32'(cycle_cnt), 0);
    chk("rst.flags", 32'({busy, finish, error}), 0);
    chk("rst.cur", 32'(cur_stage), 0);
    rst_n = 1;
  endtask

  typedef struct {
    logic st, ab;
    logic [N-1:0] sk, dn;
    logic [N-1:0] en, sp;
    int cur;
    logic bsy, fin;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic st, logic ab, logic [N-1:0] sk, logic [N-1:0] dn,
                     logic [N-1:0] en, logic [N-1:0] sp, int cur,
                     logic bsy, logic fin, int cnt);
    vec_t v;
    v.st = st; v.ab = ab; v.sk = sk; v.dn = dn;
    v.en = en; v.sp = sp; v.cur = cur;
    v.bsy = bsy; v.fin = fin; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    // mask 01010 with done held: stages 0,2,4 one cycle each
    add(1, 0, 5'b01010, 5'b11111, 5'b00001, 5'b00001, 0, 1, 0, 0);
    add(0, 0, 5'b00000, 5'b11111, 5'b00100, 5'b00100, 2, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b11111, 5'b10000, 5'b10000, 4, 1, 0, 2);
    add(0, 0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 4, 0, 1, 3);
    add(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 4, 0, 1, 3);
    // all skipped: straight to DONE
    add(1, 0, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 0);
    add(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0, 1, 0);
    // restart from DONE, inactive done ignored
    add(1, 0, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 0, 1, 0, 0);
    add(0, 0, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b00010, 5'b00001, 5'b00000, 0, 1, 0, 2);
    add(0, 0, 5'b00000, 5'b00001, 5'b00010, 5'b00010, 1, 1, 0, 3);
    add(0, 0, 5'b00000, 5'b00010, 5'b00100, 5'b00100, 2, 1, 0, 4);
    // abort beats start and done
    add(1, 1, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 0, 0, 0, 0);
    add(0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);
    add(1, 0, 5'b00111, 5'b00000, 5'b01000, 5'b01000, 3, 1, 0, 0);
    add(0, 0, 5'b00000, 5'b01000, 5'b10000, 5'b10000, 4, 1, 0, 1);
    add(0, 0, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 4, 0, 1, 2);
    add(0, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0);

    @(negedge clk);
    do_reset();

    foreach (tbl[k]) begin
      cyc(tbl[k].st, tbl[k].ab, tbl[k].sk, tbl[k].dn);
      chk($sformatf("v%0d.en", k), 32'(stage_en), 32'(tbl[k].en));
      chk($sformatf("v%0d.sp", k), 32'(stage_start), 32'(tbl[k].sp));
      chk($sformatf("v%0d.cur", k), 32'(cur_stage), 32'(tbl[k].cur));
      chk($sformatf("v%0d.st", k), 32'({busy, finish}),
          32'({tbl[k].bsy, tbl[k].fin}));
      chk($sformatf("v%0d.cnt", k), 32'(cycle_cnt), 32'(tbl[k].cnt));
    end

    // full run, done pulse 3 cycles after each enable
    cyc(1, 0, '0, '0);
    for (int s = 0; s < N; s++) begin
      chk($sformatf("full.en%0d", s), 32'(stage_en), 32'(1 << s));
      chk($sformatf("full.sp%0d", s), 32'(stage_start), 32'(1 << s));
      repeat (3) cyc(0, 0, '0, '0);
      cyc(0, 0, '0, N'(1 << s));
    end
    chk("full.fin", 32'(finish), 1);
    chk("full.cnt", 32'(cycle_cnt), 20);

    // asynchronous reset in the middle of a run
    cyc(1, 0, '0, '0);
    cyc(0, 0, '0, 5'b00001);
    #2 rst_n = 0;
    #1;
    chk("arst.en", 32'(stage_en), 0);
    chk("arst.flags", 32'({busy, finish, error}), 0);
    chk("arst.cnt", 32'(cycle_cnt), 0);
    chk("arst.cur", 32'(cur_stage), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

`ifdef SEQ_WATCHDOG_EN
    // stage 1 never completes
    cyc(1, 0, '0, 5'b00001);
    cyc(0, 0, '0, 5'b00001);
    repeat (TO - 1) cyc(0, 0, '0, '0);
    chk("wd.busy", 32'(busy), 1);
    cyc(0, 0, '0, '0);
    chk("wd.err", 32'(error), 1);
    chk("wd.cur", 32'(cur_stage), 1);
    chk("wd.en", 32'(stage_en), 0);
    cyc(1, 0, '0, '0);
    chk("wd.restart", 32'(stage_en), 1);
    cyc(0, 1, '0, '0);
`else
    chk("noerr", 32'(error), 0);
`endif

    for (int c = 0; c < 4000; c++) begin
      logic st, ab;
      logic [N-1:0] sk, dn;
      st = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 60) == 0);
      sk = N'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) sk = '0;
      dn = N'($urandom_range(0, 31));
      cyc(st, ab, sk, dn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
